// File: rtl/mux3_arb_pkg.sv
// rtl/mux3_arb_pkg.sv - shared types, constants and rotated-priority helper for mux3_rr_arbiter
// Contents: state_e (IDLE/BUSY), SEL_NONE, NUM_REQ, PTR_RESET, prio_idx().
package mux3_arb_pkg;

    localparam int         NUM_REQ   = 3;
    localparam logic [1:0] SEL_NONE  = 2'd3;
    // Last-granted index after reset; 2 makes requester 0 the first winner.
    localparam logic [1:0] PTR_RESET = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Requester index holding priority rank 'rank' (0 = highest) when 'ptr'
    // was granted last: (ptr + 1 + rank) mod 3. With ptr, rank <= 2 the sum
    // is at most 5, so a single conditional subtraction is enough.
    function automatic logic [1:0] prio_idx(input logic [1:0] ptr, input logic [1:0] rank);
        logic [2:0] sum;
        sum = {1'b0, ptr} + {1'b0, rank} + 3'd1;
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

endpackage

// File: rtl/mux3_rr_arbiter_if.sv
// rtl/mux3_rr_arbiter_if.sv - requester/consumer bundle for mux3_rr_arbiter
// Signals: req, data0..2, ack (requesters); y, y_valid, y_ready, sel (consumer);
// lock only when MUX3_ARB_LOCK_EN is defined.
// Modports: master = bench/producers+consumer side, slave = arbiter side.
interface mux3_rr_arbiter_if
    import mux3_arb_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [NUM_REQ-1:0] req;
    logic [WIDTH-1:0]   data0;
    logic [WIDTH-1:0]   data1;
    logic [WIDTH-1:0]   data2;
    logic [NUM_REQ-1:0] ack;
    logic [WIDTH-1:0]   y;
    logic               y_valid;
    logic               y_ready;
    logic [1:0]         sel;
`ifdef MUX3_ARB_LOCK_EN
    logic [NUM_REQ-1:0] lock;

    modport master (output req, data0, data1, data2, y_ready, lock,
                    input  ack, y, y_valid, sel);
    modport slave  (input  req, data0, data1, data2, y_ready, lock,
                    output ack, y, y_valid, sel);
`else
    modport master (output req, data0, data1, data2, y_ready,
                    input  ack, y, y_valid, sel);
    modport slave  (input  req, data0, data1, data2, y_ready,
                    output ack, y, y_valid, sel);
`endif
endinterface

// File: rtl/mux3_rr_arbiter_mux.sv
// rtl/mux3_rr_arbiter_mux.sv - 3:1 selection datapath built as a two-stage 2:1 mux tree
// Ports: sel_i (0..2), d0_i/d1_i/d2_i (WIDTH), y_o (WIDTH). sel_i=3 yields d2_i.
module mux3_tree #(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] d0_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    output logic [WIDTH-1:0] y_o
);
    logic [WIDTH-1:0] stage1;

    assign stage1 = sel_i[0] ? d1_i : d0_i;
    assign y_o    = sel_i[1] ? d2_i : stage1;

endmodule

// File: rtl/mux3_rr_arbiter_pick.sv
// rtl/mux3_rr_arbiter_pick.sv - combinational rotated-priority picker rr_pick3
// Ports: req_i[2:0], ptr_i (last grant), lock_i/owner_i (MUX3_ARB_LOCK_EN only),
//        grant_o (winning index, meaningful only when any_req_o), any_req_o.
module rr_pick3
    import mux3_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         ptr_i,
`ifdef MUX3_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] lock_i,
    input  logic [1:0]         owner_i,
`endif
    output logic [1:0]         grant_o,
    output logic               any_req_o
);
    logic [1:0] p0;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] rr_grant;

    assign p0 = prio_idx(ptr_i, 2'd0);
    assign p1 = prio_idx(ptr_i, 2'd1);
    assign p2 = prio_idx(ptr_i, 2'd2);

    // p2 is the fallback: either it is the only requester left or nobody
    // requests and the grant is ignored.
    always_comb begin
        rr_grant = p2;
        if (req_i[p0]) begin
            rr_grant = p0;
        end else if (req_i[p1]) begin
            rr_grant = p1;
        end
    end

`ifdef MUX3_ARB_LOCK_EN
    logic owner_keep;
    // Only the current owner of y may hold on to the channel.
    assign owner_keep = (owner_i != SEL_NONE) && lock_i[owner_i] && req_i[owner_i];
    assign grant_o    = owner_keep ? owner_i : rr_grant;
`else
    assign grant_o    = rr_grant;
`endif

    assign any_req_o = |req_i;

endmodule

// File: rtl/mux3_rr_arbiter.sv
// rtl/mux3_rr_arbiter.sv - round-robin arbiter sharing one registered output among three requesters
// Ports: clk_i, rst_i (sync, active-high), bus (mux3_rr_arbiter_if.slave).
// Optional feature: define MUX3_ARB_LOCK_EN to add bus.lock (owner keeps the grant).
module mux3_rr_arbiter
    import mux3_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mux3_rr_arbiter_if.slave bus
);
    state_e           state_q;
    logic [WIDTH-1:0] y_q;
    logic [1:0]       sel_q;
    logic [1:0]       ptr_q;

    logic [1:0]       grant;
    logic             any_req;
    logic             free;
    logic             load;
    logic [WIDTH-1:0] mux_y;

    rr_pick3 u_pick (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
`ifdef MUX3_ARB_LOCK_EN
        .lock_i    (bus.lock),
        .owner_i   (sel_q),
`endif
        .grant_o   (grant),
        .any_req_o (any_req)
    );

    mux3_tree #(.WIDTH(WIDTH)) u_mux (
        .sel_i (grant),
        .d0_i  (bus.data0),
        .d1_i  (bus.data1),
        .d2_i  (bus.data2),
        .y_o   (mux_y)
    );

    // The register can take a new word when empty or when its word leaves
    // this cycle. Reset suppresses load so no ack escapes during reset.
    assign free    = (state_q == IDLE) || bus.y_ready;
    assign load    = free && any_req && !rst_i;
    assign bus.ack = load ? (3'b001 << grant) : 3'b000;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            y_q     <= '0;
            sel_q   <= SEL_NONE;
            ptr_q   <= PTR_RESET;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        y_q     <= mux_y;
                        sel_q   <= grant;
                        ptr_q   <= grant;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.y_ready) begin
                        if (load) begin
                            y_q   <= mux_y;
                            sel_q <= grant;
                            ptr_q <= grant;
                        end else begin
                            sel_q   <= SEL_NONE;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = (state_q == BUSY);
    assign bus.sel     = sel_q;

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// tb/tb_mux3_rr_arbiter.sv - self-checking bench for mux3_rr_arbiter
module tb_mux3_rr_arbiter;
    import mux3_arb_pkg::*;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux3_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux3_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    logic [2:0]       r_req;
    logic [WIDTH-1:0] r_data [3];
    logic             r_ready;

    assign bus.req     = r_req;
    assign bus.data0   = r_data[0];
    assign bus.data1   = r_data[1];
    assign bus.data2   = r_data[2];
    assign bus.y_ready = r_ready;
`ifdef MUX3_ARB_LOCK_EN
    logic [2:0] r_lock = 3'b000;
    assign bus.lock = r_lock;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the consumer should see, plus the last winner.
    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_y     = '0;
    logic [1:0]       m_sel   = 2'd3;
    int               m_last  = 2;
    logic             n_valid;
    logic [WIDTH-1:0] n_y;
    logic [1:0]       n_sel;
    int               n_last;
    logic [2:0]       exp_ack;

    task automatic predict();
        bit free;
        int g;
        free    = !m_valid || r_ready;
        exp_ack = 3'b000;
        n_valid = m_valid;
        n_y     = m_y;
        n_sel   = m_sel;
        n_last  = m_last;
        if (rst) begin
            n_valid = 1'b0;
            n_y     = '0;
            n_sel   = 2'd3;
            n_last  = 2;
        end else if (free && r_req != 3'b000) begin
            g = -1;
`ifdef MUX3_ARB_LOCK_EN
            if (m_sel != 2'd3 && r_lock[m_sel] && r_req[m_sel]) g = int'(m_sel);
`endif
            for (int k = 1; k <= 3; k++) begin
                if (g < 0 && r_req[(m_last + k) % 3]) g = (m_last + k) % 3;
            end
            exp_ack = 3'(1 << g);
            n_valid = 1'b1;
            n_y     = r_data[g];
            n_sel   = 2'(g);
            n_last  = g;
        end else if (free) begin
            n_valid = 1'b0;
            n_sel   = 2'd3;
        end
    endtask

    task automatic settle();
        #1;
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_valid = n_valid;
        m_y     = n_y;
        m_sel   = n_sel;
        m_last  = n_last;
    endtask

    task automatic test_reset();
        rst = 1'b1; r_req = 3'b111; r_ready = 1'b1;
        r_data[0] = 8'hA0; r_data[1] = 8'hB1; r_data[2] = 8'hC2;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++;
            if (bus.ack !== 3'b000) begin
                n_fail++; $display("FAIL reset_ack[%0d]: got %b expected 000", i, bus.ack);
            end
            tick();
            n_checks++;
            if (bus.y_valid !== 1'b0 || bus.sel !== 2'd3 || bus.y !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got valid=%b sel=%0d y=%h expected valid=0 sel=3 y=00",
                         i, bus.y_valid, bus.sel, bus.y);
            end
        end
        rst = 1'b0;
        settle();
        n_checks++;
        if (bus.ack !== 3'b001) begin
            n_fail++; $display("FAIL first_ack: got %b expected 001", bus.ack);
        end
        tick();
        n_checks++;
        if (bus.y !== 8'hA0 || bus.sel !== 2'd0 || bus.y_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_word: got y=%h sel=%0d valid=%b expected y=a0 sel=0 valid=1",
                     bus.y, bus.sel, bus.y_valid);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] ea;
        for (int i = 0; i < 4; i++) begin
            ea = 3'(1 << ((i + 1) % 3));
            settle();
            n_checks++;
            if (bus.ack !== ea) begin
                n_fail++; $display("FAIL rot_ack[%0d]: got %b expected %b", i, bus.ack, ea);
            end
            tick();
            n_checks++;
            if (bus.y !== r_data[(i + 1) % 3] || bus.sel !== 2'((i + 1) % 3)) begin
                n_fail++;
                $display("FAIL rot_word[%0d]: got y=%h sel=%0d expected y=%h sel=%0d",
                         i, bus.y, bus.sel, r_data[(i + 1) % 3], (i + 1) % 3);
            end
        end
    endtask

    task automatic test_stall();
        r_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            n_checks++;
            if (bus.ack !== 3'b000) begin
                n_fail++; $display("FAIL stall_ack[%0d]: got %b expected 000", i, bus.ack);
            end
            tick();
            n_checks++;
            if (bus.y !== 8'hB1 || bus.y_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got y=%h valid=%b expected y=b1 valid=1", i, bus.y, bus.y_valid);
            end
        end
        r_ready = 1'b1;
        settle();
        n_checks++;
        if (bus.ack !== 3'b100) begin
            n_fail++; $display("FAIL stall_release_ack: got %b expected 100", bus.ack);
        end
        tick();
        n_checks++;
        if (bus.y !== 8'hC2 || bus.sel !== 2'd2) begin
            n_fail++; $display("FAIL stall_release_word: got y=%h sel=%0d expected y=c2 sel=2", bus.y, bus.sel);
        end
    endtask

    task automatic test_single();
        logic [2:0] seq [2];
        r_req = 3'b100;
        for (int i = 0; i < 4; i++) begin
            settle();
            n_checks++;
            if (bus.ack !== 3'b100) begin
                n_fail++; $display("FAIL single_ack[%0d]: got %b expected 100", i, bus.ack);
            end
            tick();
            n_checks++;
            if (bus.sel !== 2'd2 || bus.y !== 8'hC2) begin
                n_fail++; $display("FAIL single_sel[%0d]: got sel=%0d y=%h expected sel=2 y=c2", i, bus.sel, bus.y);
            end
        end
        r_req = 3'b101;
        seq[0] = 3'b001; seq[1] = 3'b100;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_checks++;
            if (bus.ack !== seq[i]) begin
                n_fail++; $display("FAIL join_ack[%0d]: got %b expected %b", i, bus.ack, seq[i]);
            end
            tick();
        end
    endtask

`ifdef MUX3_ARB_LOCK_EN
    task automatic test_lock();
        logic [2:0] seq [6];
        seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b010;
        seq[3] = 3'b010; seq[4] = 3'b010; seq[5] = 3'b100;
        r_req = 3'b111; r_ready = 1'b1; r_lock = 3'b010;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) r_lock = 3'b000;
            settle();
            n_checks++;
            if (bus.ack !== seq[i]) begin
                n_fail++; $display("FAIL lock_ack[%0d]: got %b expected %b", i, bus.ack, seq[i]);
            end
            tick();
        end
    endtask
`endif

    task automatic test_reset_mid();
        r_req = 3'b100; r_ready = 1'b1;
        settle();
        tick();
        n_checks++;
        if (bus.y !== 8'hC2 || bus.y_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: got y=%h valid=%b expected y=c2 valid=1", bus.y, bus.y_valid);
        end
        rst = 1'b1; r_ready = 1'b0; r_req = 3'b111;
        settle();
        n_checks++;
        if (bus.ack !== 3'b000) begin
            n_fail++; $display("FAIL mid_rst_ack: got %b expected 000", bus.ack);
        end
        tick();
        n_checks++;
        if (bus.y_valid !== 1'b0 || bus.sel !== 2'd3) begin
            n_fail++; $display("FAIL mid_rst_state: got valid=%b sel=%0d expected valid=0 sel=3", bus.y_valid, bus.sel);
        end
        rst = 1'b0; r_ready = 1'b1;
        settle();
        n_checks++;
        if (bus.ack !== 3'b001) begin
            n_fail++; $display("FAIL mid_next_ack: got %b expected 001", bus.ack);
        end
        tick();
        n_checks++;
        if (bus.y !== 8'hA0 || bus.sel !== 2'd0) begin
            n_fail++; $display("FAIL mid_next_word: got y=%h sel=%0d expected y=a0 sel=0", bus.y, bus.sel);
        end
    endtask

    task automatic test_random();
        logic [2:0] acked;
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 63) == 0);
            r_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX3_ARB_LOCK_EN
            r_lock  = 3'($urandom_range(0, 7));
`endif
            settle();
            n_checks++;
            if (bus.ack !== exp_ack) begin
                n_fail++; $display("FAIL rand_ack[%0d]: got %b expected %b", c, bus.ack, exp_ack);
            end
            acked = exp_ack;
            tick();
            n_checks++;
            if (bus.y !== m_y || bus.y_valid !== m_valid || bus.sel !== m_sel) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got y=%h valid=%b sel=%0d expected y=%h valid=%b sel=%0d",
                         c, bus.y, bus.y_valid, bus.sel, m_y, m_valid, m_sel);
            end
            // Requesters hold req and data until accepted, then may move on.
            for (int i = 0; i < 3; i++) begin
                if (acked[i] || !r_req[i]) begin
                    r_req[i]  = 1'($urandom_range(0, 1));
                    r_data[i] = 8'($urandom);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_stall();
        test_single();
`ifdef MUX3_ARB_LOCK_EN
        test_lock();
`endif
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux3_rr_arbiter.md
# mux3_rr_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit output channel among three requesters. It drives the select of the team's 3:1 selection datapath (a two-stage 2:1 mux tree) and registers the selected word behind a valid/ready handshake. Each requester gets a per-cycle accept strobe. The block sits between independent producers and a single downstream consumer.

## Interface
- WIDTH, 8, data width of every requester word and of the output.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  3  req[i]: requester i has a word on data_i; held with data stable until accepted.
- data0, data1, data2  in  WIDTH  requester words.
- ack  out  3  one-hot accept strobe; ack[i] high in a cycle means data_i is captured at that rising edge.
- y  out  WIDTH  registered output word.
- y_valid  out  1  y holds an unconsumed word.
- y_ready  in  1  consumer accepts y when y_valid && y_ready at a rising edge.
- sel  out  2  requester that owns the word in y (0..2); 3 = none.
- lock  in  3  present only with MUX3_ARB_LOCK_EN; lock[i] asks to keep the grant.

## Operation
- Output register "free" = !y_valid || y_ready. load = free && |req && !rst.
- Grant on load: first requesting index in priority order (ptr+1)%3, (ptr+2)%3, ptr, where ptr is the last granted index.
- ack = load ? onehot(grant) : 3'b000. ack is combinational from req/y_ready/state; no other output is combinational.
- On load: y <= data_grant (through the 3:1 mux tree, select = grant); y_valid <= 1; sel <= grant; ptr <= grant.
- Free with no req: y_valid <= 0; sel <= 3; y and ptr hold.
- Not free (y_valid && !y_ready): y, sel, ptr hold; ack = 0; req lines wait.
- FSM: IDLE (y_valid=0) and BUSY (y_valid=1).
  - IDLE -> BUSY on load.
  - BUSY -> BUSY on a handshake with load (back-to-back transfer), or with no handshake.
  - BUSY -> IDLE on a handshake with no req.
- A requester that drops req without ack loses nothing and is simply skipped. Dropping req is legal only after ack; the block does not check this.
- Reset values: y_valid=0, sel=3, y=0, ack=0, ptr=2 (requester 0 wins the first arbitration), state IDLE.
- Reset mid-transfer: the word in y is discarded and no ack is issued during reset cycles, even when req is high.

## Timing
- Latency: req[i] high in cycle N with the register free -> ack[i] in cycle N -> y/y_valid/sel valid in N+1.
- Throughput: one word per cycle with y_ready held high and continuous requests.
- Fairness: with all three requesting continuously, each is granted exactly once per 3 transfers. Maximum wait is 2 transfers after the register frees.
- A stall (y_ready=0) freezes the arbitration order; ptr does not advance.

## Configuration
- MUX3_ARB_LOCK_EN defined:
  - lock port exists.
  - On load, if sel holds requester g (sel != 3), lock[g]=1 and req[g]=1, then g is granted again regardless of ptr.
  - A lock on a non-owner requester is ignored.
  - Lock never overrides a stall or reset.
- MUX3_ARB_LOCK_EN undefined: lock port absent; pure round-robin.

## Structure
- Package mux3_arb_pkg:
  - state enum {IDLE, BUSY};
  - SEL_NONE = 2'd3;
  - NUM_REQ = 3;
  - the rotated-priority function.
- Sub-module rr_pick3: purely combinational. Inputs req[2:0], ptr[1:0] (plus lock override inputs when enabled). Outputs grant index and any_req.
- Top level holds the FSM, ptr, output register and the mux instance.

## Test plan
- Reset with req=3'b111 held 2 cycles -> ack=0, y_valid=0, sel=3 throughout. First cycle after release: ack=3'b001, then y=data0, sel=0.
- req=3'b111, y_ready=1, data0=0xA0, data1=0xB1, data2=0xC2 -> y sequence A0,B1,C2,A0,... one per cycle; ack sequence 001,010,100,001.
- y_valid=1 with y=0xB1, y_ready=0 for 5 cycles, req=3'b111 -> y stays 0xB1 and ack=0 for all 5. y_ready=1 -> ack=3'b100, y=0xC2 next cycle.
- Only req[2] high -> granted every cycle, sel=2. Then raise req[0] -> next grant is 0, then 2.
- With MUX3_ARB_LOCK_EN: req=3'b111, lock=3'b010 after requester 1 is granted -> requester 1 granted 4 consecutive times. Drop lock -> next grant 2.
- rst pulsed one cycle while BUSY with y=0xC2 -> y_valid=0, sel=3 after the edge. Next grant goes to requester 0.
